// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: operation enumeration, opcode/funct values and
// instruction field bit positions, used by both the encoder and the decoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_XOR  = 5'd2,
    OP_JR   = 5'd3,
    OP_JALR = 5'd4,
    OP_SLL  = 5'd5,
    OP_ORI  = 5'd6,
    OP_LW   = 5'd7,
    OP_SW   = 5'd8,
    OP_BEQ  = 5'd9,
    OP_LUI  = 5'd10,
    OP_JAL  = 5'd11,
    OP_J    = 5'd12,
    OP_LB   = 5'd13,
    OP_BGTZ = 5'd14,
    OP_ADDI = 5'd15,
    OP_LWIE = 5'd16
  } op_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_LB    = 6'b100000;
  localparam logic [5:0] OPC_BGTZ  = 6'b000111;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LWIE  = 6'b111000;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_SLL  = 6'b000000;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SH_MSB    = 10;
  localparam int SH_LSB    = 6;
  localparam int FN_MSB    = 5;
  localparam int FN_LSB    = 0;
  localparam int IMM16_MSB = 15;
  localparam int IMM26_MSB = 25;

  function automatic logic [5:0] r_funct(input logic [4:0] op);
    case (op)
      OP_ADD:  return FN_ADD;
      OP_SUB:  return FN_SUB;
      OP_XOR:  return FN_XOR;
      OP_JR:   return FN_JR;
      OP_JALR: return FN_JALR;
      default: return FN_SLL;
    endcase
  endfunction

  function automatic logic [5:0] ij_opcode(input logic [4:0] op);
    case (op)
      OP_ORI:  return OPC_ORI;
      OP_LW:   return OPC_LW;
      OP_SW:   return OPC_SW;
      OP_BEQ:  return OPC_BEQ;
      OP_LUI:  return OPC_LUI;
      OP_JAL:  return OPC_JAL;
      OP_J:    return OPC_J;
      OP_LB:   return OPC_LB;
      OP_BGTZ: return OPC_BGTZ;
      OP_ADDI: return OPC_ADDI;
      OP_LWIE: return OPC_LWIE;
      default: return OPC_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS word packer: op plus raw fields in, encoded word and a
// legal flag out. Fields an op does not use are left at zero.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic [31:0] instr,
  output logic        legal
);

  always_comb begin
    instr = '0;
    legal = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_XOR, OP_JR, OP_JALR, OP_SLL: begin
        // R-type keeps a zero opcode; which register fields survive depends on op
        instr[FN_MSB:FN_LSB] = r_funct(op);
        if (op != OP_SLL) instr[RS_MSB:RS_LSB] = rs;
        if (op inside {OP_ADD, OP_SUB, OP_XOR, OP_SLL}) instr[RT_MSB:RT_LSB] = rt;
        if (op != OP_JR) instr[RD_MSB:RD_LSB] = rd;
        if (op == OP_SLL) instr[SH_MSB:SH_LSB] = shamt;
      end
      OP_LUI: begin
        instr[OPC_MSB:OPC_LSB] = ij_opcode(op);
        instr[RT_MSB:RT_LSB]   = rt;
        instr[IMM16_MSB:0]     = imm16;
      end
      OP_BGTZ: begin
        instr[OPC_MSB:OPC_LSB] = ij_opcode(op);
        instr[RS_MSB:RS_LSB]   = rs;
        instr[IMM16_MSB:0]     = imm16;
      end
      OP_J, OP_JAL: begin
        instr[OPC_MSB:OPC_LSB] = ij_opcode(op);
        instr[IMM26_MSB:0]     = imm26;
      end
      OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_LB, OP_ADDI, OP_LWIE: begin
        instr[OPC_MSB:OPC_LSB] = ij_opcode(op);
        instr[RS_MSB:RS_LSB]   = rs;
        instr[RT_MSB:RT_LSB]   = rt;
        instr[IMM16_MSB:0]     = imm16;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs requests into MIPS words behind a one-deep
// ready/valid output register, assigning sequential byte addresses.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_op,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm16,
  input  logic [25:0] in_imm26,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  logic [31:0] pack_instr;
  logic        pack_legal;
  logic        accept;
  logic        handoff;

  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_addr_q,  out_addr_d;
  logic [31:0] addr_q,      addr_d;
  logic        err_q,       err_d;
  logic [15:0] count_q,     count_d;

  instr_pack u_pack (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .shamt (in_shamt),
    .imm16 (in_imm16),
    .imm26 (in_imm26),
    .instr (pack_instr),
    .legal (pack_legal)
  );

  // Ready is forced high in reset so upstream drains; those requests are dropped.
  assign in_ready = reset | ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~reset;
  assign handoff  = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    count_d     = count_q;
    if (handoff) begin
      out_valid_d = 1'b0;
      count_d     = count_q + 16'd1;
    end
    if (accept) begin
      if (pack_legal) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_instr;
        out_addr_d  = addr_q;
        addr_d      = addr_q + 32'd4;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= BASE_ADDR;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus a randomized run
// against a table-driven reference encoder and handshake model.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op, in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm16;
  logic [25:0] in_imm26;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Reference tables indexed by op code 0..16.
  int opc_t [17] = '{0, 0, 0, 0, 0, 0, 13, 35, 43, 4, 15, 3, 2, 32, 7, 8, 56};
  int fn_t  [17] = '{32, 34, 38, 8, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int u_rs  [17] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  int u_rt  [17] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 1, 0, 1, 1};
  int u_rd  [17] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int u_sh  [17] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int u_i16 [17] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1};
  int u_i26 [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm16  (in_imm16),
    .in_imm26  (in_imm26),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_encode(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [4:0] sh,
                                             input logic [15:0] i16, input logic [25:0] i26);
    longint w;
    w = longint'(opc_t[op]) * 64'd67108864 + longint'(fn_t[op]);
    if (u_rs[op] != 0)  w += longint'(rs) * 64'd2097152;
    if (u_rt[op] != 0)  w += longint'(rt) * 64'd65536;
    if (u_rd[op] != 0)  w += longint'(rd) * 64'd2048;
    if (u_sh[op] != 0)  w += longint'(sh) * 64'd64;
    if (u_i16[op] != 0) w += longint'(i16);
    if (u_i26[op] != 0) w += longint'(i26);
    return w[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int op, input int rs, input int rt, input int rd, input int sh,
                           input int i16, input int i26);
    in_valid = 1'b1;
    in_op    = 5'(op);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_shamt = 5'(sh);
    in_imm16 = 16'(i16);
    in_imm26 = 26'(i26);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive_req(0, 1, 2, 3, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    // Hold a word, then reset while a new request is presented.
    reset = 1'b1;
    drive_req(6, 1, 1, 0, 0, 16'h5555, 0);
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
    reset = 1'b0; in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++;
    if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr got=%h exp=0", out_instr); end
    vectors++;
    if (out_addr !== BASE) begin miscompares++; $display("FAIL reset_out_addr got=%h exp=%h", out_addr, BASE); end
    vectors++;
    if (err !== 1'b0 || count !== 16'd0) begin
      miscompares++; $display("FAIL reset_err_count got=%b/%0d exp=0/0", err, count);
    end
  endtask

  task automatic test_add();
    do_reset();
    drive_req(0, 1, 2, 3, 7, 16'hFFFF, 0);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0022_1820 || out_addr !== BASE) begin
      miscompares++;
      $display("FAIL add_word got=%b %h@%h exp=1 00221820@%h", out_valid, out_instr, out_addr, BASE);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b1;
    drive_req(6, 0, 1, 0, 0, 16'h1234, 0);
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3401_1234 || out_addr !== 32'h3000) begin
      miscompares++; $display("FAIL b2b_ori got=%b %h@%h exp=1 34011234@3000", out_valid, out_instr, out_addr);
    end
    drive_req(7, 5, 4, 0, 0, 8, 0);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h8CA4_0008 || out_addr !== 32'h3004) begin
      miscompares++; $display("FAIL b2b_lw got=%b %h@%h exp=1 8ca40008@3004", out_valid, out_instr, out_addr);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || count !== 16'd2) begin
      miscompares++; $display("FAIL b2b_count got=%b/%0d exp=0/2", out_valid, count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_req(5, 9, 3, 2, 4, 0, 0);
    tick();
    // Keep offering a different request; it must not be taken while stalled.
    drive_req(1, 7, 7, 7, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_instr !== 32'h0003_1100 || out_addr !== BASE || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got=%b %h@%h rdy=%b exp=1 00031100@3000 rdy=0",
                 i, out_valid, out_instr, out_addr, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (out_valid !== 1'b0 || count !== 16'd1) begin
      miscompares++; $display("FAIL stall_release got=%b/%0d exp=0/1", out_valid, count);
    end
    tick();
    vectors++;
    if (count !== 16'd1) begin miscompares++; $display("FAIL stall_once got=%0d exp=1", count); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    drive_req(20, 1, 2, 3, 4, 16'h1111, 26'h3FF_FFFF);
    tick();
    vectors++;
    if (out_valid !== 1'b0 || err !== 1'b1) begin
      miscompares++; $display("FAIL illegal_op got=%b err=%b exp=0 err=1", out_valid, err);
    end
    drive_req(11, 0, 0, 0, 0, 0, 26'h000_0C00);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h0C00_0C00 || out_addr !== BASE || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_jal got=%b %h@%h err=%b exp=1 0c000c00@3000 err=1", out_valid, out_instr, out_addr, err);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_req(31, 0, 0, 0, 0, 0, 0);
    tick();
    drive_req(2, 4, 5, 6, 0, 0, 0);
    tick();
    drive_req(2, 4, 5, 6, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || count !== 16'd0 || err !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0", out_valid, count, err);
    end
    out_ready = 1'b1;
    drive_req(10, 9, 8, 0, 0, 16'hBEEF, 0);
    tick();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_instr !== 32'h3C08_BEEF || out_addr !== BASE) begin
      miscompares++; $display("FAIL mid_next got=%b %h@%h exp=1 3c08beef@3000", out_valid, out_instr, out_addr);
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_err, acc, ho;
    logic [31:0] m_instr, m_addr, m_next;
    logic [15:0] m_count;
    int          op;
    do_reset();
    m_valid = 1'b0; m_err = 1'b0; m_count = '0;
    m_instr = '0; m_addr = BASE; m_next = BASE;
    for (int cyc = 0; cyc < 800; cyc++) begin
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      drive_req(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 65535), $urandom_range(0, 67108863));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      vectors++;
      if (in_ready !== (!m_valid || out_ready)) begin
        miscompares++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !m_valid || out_ready);
      end
      acc = in_valid && (!m_valid || out_ready);
      ho  = m_valid && out_ready;
      if (ho) begin m_count = m_count + 16'd1; m_valid = 1'b0; end
      if (acc && op <= 16) begin
        m_valid = 1'b1;
        m_instr = ref_encode(op, in_rs, in_rt, in_rd, in_shamt, in_imm16, in_imm26);
        m_addr  = m_next;
        m_next  = m_next + 32'd4;
      end else if (acc) begin
        m_err = 1'b1;
      end
      tick();
      vectors++;
      if (out_valid !== m_valid) begin
        miscompares++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if (out_instr !== m_instr || out_addr !== m_addr) begin
          miscompares++;
          $display("FAIL rnd_word cyc=%0d got=%h@%h exp=%h@%h", cyc, out_instr, out_addr, m_instr, m_addr);
        end
      end
      vectors++;
      if (err !== m_err || count !== m_count) begin
        miscompares++; $display("FAIL rnd_err_count cyc=%0d got=%b/%0d exp=%b/%0d", cyc, err, count, m_err, m_count);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm16 = '0; in_imm26 = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
